// File: rtl/mm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// mm_seq_ctrl : operand/result register files and feed sequencer for a
//               SIZE x SIZE systolic matrix-multiply array.
// Revision    : 1.0
// ============================================================================
module mm_seq_ctrl #(
  parameter int SIZE         = 3,
  parameter int DATA_WIDTH   = 8,
  parameter int SKEW         = 0,
  parameter int DRAIN_CYCLES = 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       ld_en,
  input  logic                                       ld_sel,
  input  logic [$clog2(SIZE)-1:0]                    ld_row,
  input  logic [$clog2(SIZE)-1:0]                    ld_col,
  input  logic signed [DATA_WIDTH-1:0]               ld_data,
  input  logic                                       start,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       arr_clear,
  output logic [SIZE-1:0][DATA_WIDTH-1:0]            arr_a,
  output logic [SIZE-1:0][DATA_WIDTH-1:0]            arr_b,
  input  logic [SIZE-1:0][SIZE-1:0][2*DATA_WIDTH-1:0] arr_c,
  input  logic [$clog2(SIZE)-1:0]                    rd_row,
  input  logic [$clog2(SIZE)-1:0]                    rd_col,
  output logic signed [2*DATA_WIDTH-1:0]             rd_data
);

  localparam int IDX_W   = $clog2(SIZE);
  localparam int F_STEPS = (SKEW != 0) ? 3*SIZE-2 : SIZE;
  localparam int K_W     = $clog2(F_STEPS);
  localparam int D_W     = $clog2(DRAIN_CYCLES+1);
  localparam logic [K_W-1:0] K_LAST = K_W'(F_STEPS-1);
  localparam logic [D_W-1:0] D_LAST = D_W'(DRAIN_CYCLES-1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]     state, next_state;
  logic [K_W-1:0] k, next_k;
  logic [D_W-1:0] dcnt, next_dcnt;
  logic           capture;

  logic signed [DATA_WIDTH-1:0]   a_mem [SIZE][SIZE];
  logic signed [DATA_WIDTH-1:0]   b_mem [SIZE][SIZE];
  logic signed [2*DATA_WIDTH-1:0] res   [SIZE][SIZE];
  logic [SIZE-1:0][DATA_WIDTH-1:0] feed_a, feed_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      k     <= '0;
      dcnt  <= '0;
    end else begin
      state <= next_state;
      k     <= next_k;
      dcnt  <= next_dcnt;
    end
  end

  always_comb begin
    next_state = state;
    next_k     = k;
    next_dcnt  = dcnt;
    case (state)
      S_IDLE, S_DONE: if (start) next_state = S_CLEAR;
      S_CLEAR: begin
        next_state = S_FEED;
        next_k     = '0;
      end
      S_FEED: begin
        if (k == K_LAST) begin
          next_state = S_DRAIN;
          next_k     = '0;
          next_dcnt  = '0;
        end else begin
          next_k = k + 1'b1;
        end
      end
      S_DRAIN: begin
        if (dcnt == D_LAST) next_state = S_DONE;
        else                next_dcnt  = dcnt + 1'b1;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == S_CLEAR) || (state == S_FEED) || (state == S_DRAIN);
    done      = (state == S_DONE);
    arr_clear = (state == S_CLEAR);
    capture   = (state == S_DRAIN) && (dcnt == D_LAST);
  end

  // Feed values are computed for the step about to start so the registered
  // outputs hold step k for the whole of FEED cycle k.
  always_comb begin
    int idx;
    feed_a = '0;
    feed_b = '0;
    idx    = 0;
    for (int i = 0; i < SIZE; i++) begin
      idx = (SKEW != 0) ? int'(next_k) - i : int'(next_k);
      if (idx >= 0 && idx < SIZE) begin
        feed_a[i] = a_mem[i][IDX_W'(idx)];
        feed_b[i] = b_mem[IDX_W'(idx)][i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arr_a <= '0;
      arr_b <= '0;
      for (int r = 0; r < SIZE; r++) begin
        for (int c = 0; c < SIZE; c++) begin
          a_mem[r][c] <= '0;
          b_mem[r][c] <= '0;
          res[r][c]   <= '0;
        end
      end
    end else begin
      if (next_state == S_FEED) begin
        arr_a <= feed_a;
        arr_b <= feed_b;
      end else begin
        arr_a <= '0;
        arr_b <= '0;
      end
      if (ld_en && !busy && (int'(ld_row) < SIZE) && (int'(ld_col) < SIZE)) begin
        if (ld_sel) b_mem[ld_row][ld_col] <= ld_data;
        else        a_mem[ld_row][ld_col] <= ld_data;
      end
      if (capture) begin
        for (int r = 0; r < SIZE; r++) begin
          for (int c = 0; c < SIZE; c++) begin
            res[r][c] <= arr_c[r][c];
          end
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if ((int'(rd_row) < SIZE) && (int'(rd_col) < SIZE)) rd_data = res[rd_row][rd_col];
  end

endmodule
`default_nettype wire

// File: tb/tb_mm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mm_seq_ctrl : directed self-checking bench; one unskewed and one skewed
//                  sequencer, each driving a behavioural array model.
// Revision       : 1.0
// ============================================================================
module tb_mm_seq_ctrl;

  typedef logic signed [7:0] mat_t [3][3];

  logic clk = 1'b0;
  logic rst;
  logic ld_en, ld_sel, start0, start1;
  logic [1:0] ld_row, ld_col, rd_row, rd_col;
  logic signed [7:0] ld_data;

  logic busy0, done0, clr0, busy1, done1, clr1;
  logic [2:0][7:0] arr_a0, arr_b0, arr_a1, arr_b1;
  logic [2:0][2:0][15:0] arr_c0, arr_c1;
  logic signed [15:0] rd0, rd1;

  logic signed [15:0] acc0 [3][3];
  logic signed [15:0] acc1 [3][3];
  logic signed [7:0]  ap [3][3];
  logic signed [7:0]  bp [3][3];
  logic signed [7:0]  ai, bi;

  int checks = 0;
  int errors = 0;

  mat_t M  = '{'{8'sd1, 8'sd2, 8'sd3}, '{8'sd4, 8'sd5, 8'sd6}, '{8'sd7, 8'sd8, 8'sd9}};
  mat_t ID = '{'{8'sd1, 8'sd0, 8'sd0}, '{8'sd0, 8'sd1, 8'sd0}, '{8'sd0, 8'sd0, 8'sd1}};
  mat_t I2 = '{'{8'sd2, 8'sd0, 8'sd0}, '{8'sd0, 8'sd2, 8'sd0}, '{8'sd0, 8'sd0, 8'sd2}};
  mat_t NG = '{'{-8'sd128, -8'sd128, -8'sd128}, '{-8'sd128, -8'sd128, -8'sd128},
               '{-8'sd128, -8'sd128, -8'sd128}};
  int   SQ [3][3] = '{'{30, 36, 42}, '{66, 81, 96}, '{102, 126, 150}};

  always #5 clk = ~clk;

  mm_seq_ctrl #(.SIZE(3), .DATA_WIDTH(8), .SKEW(0), .DRAIN_CYCLES(1)) dut0 (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_sel(ld_sel), .ld_row(ld_row),
    .ld_col(ld_col), .ld_data(ld_data), .start(start0), .busy(busy0),
    .done(done0), .arr_clear(clr0), .arr_a(arr_a0), .arr_b(arr_b0),
    .arr_c(arr_c0), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd0));

  mm_seq_ctrl #(.SIZE(3), .DATA_WIDTH(8), .SKEW(1), .DRAIN_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_sel(ld_sel), .ld_row(ld_row),
    .ld_col(ld_col), .ld_data(ld_data), .start(start1), .busy(busy1),
    .done(done1), .arr_clear(clr1), .arr_a(arr_a1), .arr_b(arr_b1),
    .arr_c(arr_c1), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd1));

  // Combinational-propagation array: every PE sees A_in[i], B_in[j] directly.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        if (clr0) acc0[i][j] <= 16'sd0;
        else      acc0[i][j] <= acc0[i][j] + ($signed(arr_a0[i]) * $signed(arr_b0[j]));
  end

  // Register-pipelined array: A moves right, B moves down one PE per cycle.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        if (j == 0) ai = $signed(arr_a1[i]); else ai = ap[i][j-1];
        if (i == 0) bi = $signed(arr_b1[j]); else bi = bp[i-1][j];
        ap[i][j] <= ai;
        bp[i][j] <= bi;
        if (clr1) acc1[i][j] <= 16'sd0;
        else      acc1[i][j] <= acc1[i][j] + (ai * bi);
      end
  end

  always_comb begin
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        arr_c0[i][j] = acc0[i][j];
        arr_c1[i][j] = acc1[i][j];
      end
  end

  task automatic load_mat(input logic sel, input mat_t m);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        ld_en = 1'b1; ld_sel = sel; ld_row = 2'(r); ld_col = 2'(c); ld_data = m[r][c];
      end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Leaves the caller at the negedge inside the CLEAR cycle.
  task automatic pulse_start(input int which);
    @(negedge clk);
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done0); end
    checks++; if (clr0 !== 1'b0) begin errors++; $display("FAIL reset_clear got %b exp 0", clr0); end
    checks++; if (arr_a0 !== 24'h0 || arr_b0 !== 24'h0) begin errors++;
      $display("FAIL reset_arr got a=%h b=%h exp 0", arr_a0, arr_b0); end
    rd_row = 2'd1; rd_col = 2'd1; #1;
    checks++; if (rd0 !== 16'sd0) begin errors++; $display("FAIL reset_rd got %0d exp 0", rd0); end
  endtask

  task automatic test_identity;
    int n, nclr;
    load_mat(1'b0, M);
    load_mat(1'b1, ID);
    pulse_start(0);
    checks++; if (clr0 !== 1'b1) begin errors++; $display("FAIL id_clear_first got %b exp 1", clr0); end
    n = 0; nclr = 0;
    while (busy0 && n < 50) begin
      if (clr0) nclr++;
      n++;
      @(negedge clk);
    end
    checks++; if (n !== 5) begin errors++; $display("FAIL id_busy_cycles got %0d exp 5", n); end
    checks++; if (nclr !== 1) begin errors++; $display("FAIL id_clear_cycles got %0d exp 1", nclr); end
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL id_done got %b exp 1", done0); end
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        rd_row = 2'(r); rd_col = 2'(c); #1;
        checks++; if (rd0 !== 16'(M[r][c])) begin errors++;
          $display("FAIL id_result[%0d][%0d] got %0d exp %0d", r, c, rd0, M[r][c]); end
      end
  endtask

  task automatic test_wrap;
    int n;
    load_mat(1'b0, NG);
    load_mat(1'b1, NG);
    pulse_start(0);
    n = 0;
    while (busy0 && n < 50) begin n++; @(negedge clk); end
    checks++; if (n !== 5) begin errors++; $display("FAIL wrap_busy_cycles got %0d exp 5", n); end
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        rd_row = 2'(r); rd_col = 2'(c); #1;
        checks++; if (rd0 !== -16'sd16384) begin errors++;
          $display("FAIL wrap_result[%0d][%0d] got %h exp c000", r, c, rd0); end
      end
  endtask

  task automatic test_midrun;
    int n;
    load_mat(1'b0, M);
    load_mat(1'b1, ID);
    pulse_start(0);
    n = 0;
    while (busy0 && n < 50) begin
      if (n == 2) begin
        start0 = 1'b1; ld_en = 1'b1; ld_sel = 1'b0; ld_row = 2'd0; ld_col = 2'd0; ld_data = 8'sd99;
      end else begin
        start0 = 1'b0; ld_en = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    start0 = 1'b0; ld_en = 1'b0;
    checks++; if (n !== 5) begin errors++; $display("FAIL midrun_busy_cycles got %0d exp 5", n); end
    rd_row = 2'd0; rd_col = 2'd0; #1;
    checks++; if (rd0 !== 16'sd1) begin errors++; $display("FAIL midrun_result00 got %0d exp 1", rd0); end
    @(negedge clk);
    checks++; if (busy0 !== 1'b0 || done0 !== 1'b1) begin errors++;
      $display("FAIL midrun_no_restart got busy=%b done=%b exp 0 1", busy0, done0); end
  endtask

  task automatic test_skew;
    int n;
    load_mat(1'b0, M);
    load_mat(1'b1, M);
    pulse_start(1);
    n = 0;
    while (busy1 && n < 50) begin
      if (n == 3) begin
        checks++; if (arr_a1 !== 24'h070503) begin errors++;
          $display("FAIL skew_arr_a_k2 got %h exp 070503", arr_a1); end
        checks++; if (arr_b1 !== 24'h030507) begin errors++;
          $display("FAIL skew_arr_b_k2 got %h exp 030507", arr_b1); end
      end
      n++;
      @(negedge clk);
    end
    checks++; if (n !== 9) begin errors++; $display("FAIL skew_busy_cycles got %0d exp 9", n); end
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL skew_done got %b exp 1", done1); end
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        rd_row = 2'(r); rd_col = 2'(c); #1;
        checks++; if (rd1 !== 16'(SQ[r][c])) begin errors++;
          $display("FAIL skew_result[%0d][%0d] got %0d exp %0d", r, c, rd1, SQ[r][c]); end
      end
  endtask

  task automatic test_out_of_range;
    rd_row = 2'd3; rd_col = 2'd0; #1;
    checks++; if (rd1 !== 16'sd0) begin errors++; $display("FAIL oor_rd_row got %0d exp 0", rd1); end
    rd_row = 2'd0; rd_col = 2'd3; #1;
    checks++; if (rd1 !== 16'sd0) begin errors++; $display("FAIL oor_rd_col got %0d exp 0", rd1); end
    rd_row = 2'd2; rd_col = 2'd2; #1;
    checks++; if (rd1 !== 16'sd150) begin errors++; $display("FAIL oor_rd_inrange got %0d exp 150", rd1); end
  endtask

  task automatic test_reset_midrun;
    int n;
    load_mat(1'b0, M);
    load_mat(1'b1, ID);
    pulse_start(0);
    @(negedge clk);
    @(negedge clk);
    checks++; if (arr_a0 !== 24'h080502) begin errors++;
      $display("FAIL rstrun_arr_a_k1 got %h exp 080502", arr_a0); end
    rd_row = 2'd2; rd_col = 2'd1;
    rst = 1'b0; #1;
    checks++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin errors++;
      $display("FAIL rstrun_flags got busy=%b done=%b exp 0 0", busy0, done0); end
    checks++; if (arr_a0 !== 24'h0 || arr_b0 !== 24'h0) begin errors++;
      $display("FAIL rstrun_arr got a=%h b=%h exp 0", arr_a0, arr_b0); end
    checks++; if (rd0 !== 16'sd0) begin errors++; $display("FAIL rstrun_rd got %0d exp 0", rd0); end
    @(negedge clk);
    rst = 1'b1;
    load_mat(1'b0, M);
    load_mat(1'b1, ID);
    pulse_start(0);
    n = 0;
    while (busy0 && n < 50) begin n++; @(negedge clk); end
    checks++; if (n !== 5) begin errors++; $display("FAIL rstrun_busy_cycles got %0d exp 5", n); end
    rd_row = 2'd2; rd_col = 2'd1; #1;
    checks++; if (rd0 !== 16'sd8) begin errors++; $display("FAIL rstrun_result21 got %0d exp 8", rd0); end
  endtask

  task automatic test_back_to_back;
    int n;
    load_mat(1'b1, I2);
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL b2b_pre_done got %b exp 1", done0); end
    @(negedge clk);
    start0 = 1'b1;
    ld_en = 1'b1; ld_sel = 1'b0; ld_row = 2'd0; ld_col = 2'd0; ld_data = 8'sd10;
    @(negedge clk);
    start0 = 1'b0; ld_en = 1'b0;
    checks++; if (done0 !== 1'b0 || busy0 !== 1'b1) begin errors++;
      $display("FAIL b2b_done_fall got done=%b busy=%b exp 0 1", done0, busy0); end
    rd_row = 2'd2; rd_col = 2'd1;
    n = 0;
    while (busy0 && n < 50) begin
      #1;
      checks++; if (rd0 !== 16'sd8) begin errors++;
        $display("FAIL b2b_old_result cycle %0d got %0d exp 8", n, rd0); end
      n++;
      @(negedge clk);
    end
    checks++; if (n !== 5) begin errors++; $display("FAIL b2b_busy_cycles got %0d exp 5", n); end
    #1;
    checks++; if (rd0 !== 16'sd16) begin errors++; $display("FAIL b2b_new21 got %0d exp 16", rd0); end
    rd_row = 2'd0; rd_col = 2'd0; #1;
    checks++; if (rd0 !== 16'sd20) begin errors++; $display("FAIL b2b_new00 got %0d exp 20", rd0); end
    rd_row = 2'd1; rd_col = 2'd1; #1;
    checks++; if (rd0 !== 16'sd10) begin errors++; $display("FAIL b2b_new11 got %0d exp 10", rd0); end
  endtask

  initial begin
    rst = 1'b0; ld_en = 1'b0; ld_sel = 1'b0; ld_row = 2'd0; ld_col = 2'd0; ld_data = 8'sd0;
    start0 = 1'b0; start1 = 1'b0; rd_row = 2'd0; rd_col = 2'd0;
    repeat (2) @(negedge clk);
    test_reset;
    rst = 1'b1;
    test_identity;
    test_wrap;
    test_midrun;
    test_skew;
    test_out_of_range;
    test_reset_midrun;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mm_seq_ctrl.md
Name: mm_seq_ctrl

Overview:
- Sequencer for the SIZE×SIZE systolic matrix-multiply array.
- Holds local A and B operand register files, loaded by a host write port.
- On start: clears the array accumulators, streams one A column / B row per cycle into the array's A_in/B_in, drains, then snapshots the array's C outputs into a result register file read by the host.
- SKEW selects unskewed feed (combinational-propagation array) or diagonal-skewed feed (register-pipelined array).

Parameters:
- SIZE, 3, matrix dimension (2..8).
- DATA_WIDTH, 8, signed operand width; results are 2*DATA_WIDTH.
- SKEW, 0, 0 = unskewed feed of SIZE steps; 1 = skewed feed of 3*SIZE-2 steps.
- DRAIN_CYCLES, 1, zero-input cycles after the last feed step before capture (≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- ld_en  in  1  operand write strobe.
- ld_sel  in  1  0 = A, 1 = B.
- ld_row  in  $clog2(SIZE)  row index.
- ld_col  in  $clog2(SIZE)  column index.
- ld_data  in  DATA_WIDTH signed  operand value.
- start  in  1  begin a multiply (single-cycle sample).
- busy  out  1  run in progress.
- done  out  1  result valid (level).
- arr_clear  out  1  drives array clear.
- arr_a  out  SIZE×DATA_WIDTH signed  drives array A_in[i].
- arr_b  out  SIZE×DATA_WIDTH signed  drives array B_in[j].
- arr_c  in  SIZE×SIZE×2*DATA_WIDTH signed  array C_out.
- rd_row  in  $clog2(SIZE)  result read row.
- rd_col  in  $clog2(SIZE)  result read column.
- rd_data  out  2*DATA_WIDTH signed  result[rd_row][rd_col], combinational read of result regs.

Behaviour:
- Reset (async, rst=0):
  - state IDLE; busy, done, arr_clear = 0; arr_a, arr_b = 0.
  - operand and result regs = 0; feed counter = 0.
- FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
  - IDLE or DONE, start=1 → CLEAR; done drops on that edge.
  - CLEAR: exactly 1 cycle; arr_clear=1, arr_a and arr_b = 0 → FEED with k=0.
  - FEED: F cycles, F = SIZE (SKEW=0) or 3*SIZE-2 (SKEW=1); k increments each cycle; after k=F-1 → DRAIN.
  - DRAIN: DRAIN_CYCLES cycles with arr_a and arr_b = 0. On the final DRAIN edge, result[r][c] ← arr_c[r][c] for all r,c → DONE.
  - DONE: done=1, busy=0; stays until the next start.
- busy=1 in CLEAR, FEED and DRAIN. A run holds busy for 1+F+DRAIN_CYCLES cycles. done rises on the edge after the last busy cycle.
- arr_a and arr_b are registered outputs. The value for feed step k is stable at the array throughout FEED cycle k.
- Feed data:
  - SKEW=0: arr_a[i] = A[i][k], arr_b[j] = B[k][j].
  - SKEW=1: arr_a[i] = A[i][k-i] when 0 ≤ k-i < SIZE, else 0; arr_b[j] = B[k-j][j] when 0 ≤ k-j < SIZE, else 0.
- Arithmetic: no rounding or saturation in this block; captured results are the array's 2*DATA_WIDTH two's-complement wrap values.
- Operand writes take effect on the clock edge when ld_en=1 and busy=0. While busy=1 they are dropped, so operands are frozen for the whole run.
- Out-of-range index handling:
  - ld_row/ld_col ≥ SIZE: write is ignored.
  - rd_row/rd_col ≥ SIZE: rd_data = 0.
- start while busy=1 is ignored (no restart, no queueing).
- start and ld_en in the same IDLE cycle: the write commits and the run sees the new value.
- Result regs are unchanged from DONE of one run until the capture edge of the next run. rd_data during a run returns the previous result.
- Reset mid-run aborts immediately to the reset values above; the next run needs new start.

Test Plan:
- SIZE=3, SKEW=0: A=[[1,2,3],[4,5,6],[7,8,9]], B=identity, start pulse → busy high exactly 5 cycles, arr_clear high in the first; done then rises; rd_data[r][c] = A[r][c] (e.g. [2][1] = 8).
- Signed wrap: all A = B = -128, SIZE=3 → every result 49152 wrapped to 16 bits = -16384 (0xC000).
- SKEW=1, A=B=[[1,2,3],[4,5,6],[7,8,9]]:
  - busy lasts 1+7+1 cycles.
  - Feed step k=2: arr_a = {3,5,7}, arr_b = {7,5,3}.
  - Results: [[30,36,42],[66,81,96],[102,126,150]].
- Mid-run: pulse start during FEED and write ld_en (A[0][0]=99) during FEED → no restart, write dropped; result uses the original A[0][0].
- Reset: assert rst=0 during FEED cycle k=1 → busy=0, done=0, arr outputs 0, rd_data=0 asynchronously. After release, reload and start → correct result.
- Back-to-back: start in the DONE cycle → done falls next edge; previous result readable until the new capture edge, then the new result.
